// File: rtl/hamming_pkg.sv
// Shared Hamming(12,8) definitions: widths, codeword bit positions and a
// reference encoder used to cross-check the external encoder.
package hamming_pkg;

  localparam int HC_DATA_W = 8;
  localparam int HC_CW_W   = 12;

  // Codeword layout, bit 11..0: d7 d6 d5 d4 p3 d3 d2 d1 p2 d0 p1 p0
  localparam int P0_POS = 0;
  localparam int P1_POS = 1;
  localparam int D0_POS = 2;
  localparam int P2_POS = 3;
  localparam int D1_POS = 4;
  localparam int D2_POS = 5;
  localparam int D3_POS = 6;
  localparam int P3_POS = 7;
  localparam int D4_POS = 8;
  localparam int D5_POS = 9;
  localparam int D6_POS = 10;
  localparam int D7_POS = 11;

  function automatic logic [HC_CW_W-1:0] hc_encode(input logic [HC_DATA_W-1:0] d);
    logic [HC_CW_W-1:0] cw;
    cw         = '0;
    cw[D0_POS] = d[0];
    cw[D1_POS] = d[1];
    cw[D2_POS] = d[2];
    cw[D3_POS] = d[3];
    cw[D4_POS] = d[4];
    cw[D5_POS] = d[5];
    cw[D6_POS] = d[6];
    cw[D7_POS] = d[7];
    cw[P0_POS] = d[6] ^ d[4] ^ d[3] ^ d[1] ^ d[0];
    cw[P1_POS] = d[6] ^ d[5] ^ d[3] ^ d[2] ^ d[0];
    cw[P2_POS] = d[7] ^ d[3] ^ d[2] ^ d[1];
    cw[P3_POS] = d[7] ^ d[6] ^ d[5] ^ d[4];
    return cw;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from i_ptr with wrap and returns a
// one-hot grant plus the granted index.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);

  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_idx;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // One extra bit so ptr+i cannot overflow before the wrap subtract
      w_sum = {1'b0, i_ptr} + (IDX_W+1)'(i);
      if (w_sum >= (IDX_W+1)'(NUM_REQ)) w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
      w_idx = w_sum[IDX_W-1:0];
      if (!o_valid && i_req[w_idx]) begin
        o_valid        = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_idx          = w_idx;
      end
    end
  end

endmodule

// File: rtl/hamming_tx_sched.sv
// Shares one single-cycle Hamming(12,8) encoder between NUM_REQ byte sources
// and queues tagged codewords for the serializer. Optional HAMMING_TX_SCHED_CHK_EN.
module hamming_tx_sched
  import hamming_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int SRC_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*8-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   enc_wren,
  output logic [HC_DATA_W-1:0]   enc_data,
  input  logic [HC_CW_W-1:0]     enc_hc,
  output logic                   cw_valid,
  output logic [HC_CW_W-1:0]     cw_data,
  output logic [SRC_W-1:0]       cw_src,
  input  logic                   cw_ready,
  output logic                   busy,
  output logic                   enc_err
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;

  // Handshakes: a transfer happens in any cycle where valid and ready are both
  // high at the rising edge; ready never depends on the same line's valid
  // except through arbitration, and valid is never withdrawn by this block.

  logic                 r_inflight;
  logic [SRC_W-1:0]     r_tag;
  logic [SRC_W-1:0]     r_rr_ptr;
  logic [CNT_W-1:0]     r_count;
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [HC_CW_W-1:0]   r_mem_cw  [FIFO_DEPTH];
  logic [SRC_W-1:0]     r_mem_src [FIFO_DEPTH];

  logic [CNT_W-1:0]     w_occ;
  logic                 w_credit;
  logic [NUM_REQ-1:0]   w_req_masked;
  logic [NUM_REQ-1:0]   w_grant;
  logic [SRC_W-1:0]     w_gidx;
  logic                 w_fire;
  logic                 w_push;
  logic                 w_pop;
  logic [HC_DATA_W-1:0] w_enc_data;

  // Credit uses registered occupancy only, so a same-cycle pop frees nothing
  assign w_occ        = r_count + CNT_W'(r_inflight);
  assign w_credit     = !rst && (w_occ < CNT_W'(FIFO_DEPTH));
  assign w_req_masked = w_credit ? req_valid : '0;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (SRC_W)
  ) u_arb (
    .i_req   (w_req_masked),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_gidx),
    .o_valid (w_fire)
  );

  always_comb begin
    w_enc_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) w_enc_data = req_data[i*8 +: 8];
    end
  end

  assign req_ready = w_grant;
  assign enc_wren  = w_fire;
  assign enc_data  = w_enc_data;

  assign w_push   = r_inflight && !rst;
  assign cw_valid = !rst && (r_count != '0);
  assign w_pop    = cw_valid && cw_ready;
  assign cw_data  = r_mem_cw[r_rd_ptr];
  assign cw_src   = r_mem_src[r_rd_ptr];
  assign busy     = !rst && (r_inflight || (r_count != '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight <= 1'b0;
      r_tag      <= '0;
      r_rr_ptr   <= '0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_inflight <= w_fire;
      if (w_fire) begin
        r_tag    <= w_gidx;
        r_rr_ptr <= (w_gidx == SRC_W'(NUM_REQ-1)) ? '0 : w_gidx + SRC_W'(1);
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_cw[r_wr_ptr]  <= enc_hc;
      r_mem_src[r_wr_ptr] <= r_tag;
    end
  end

`ifdef HAMMING_TX_SCHED_CHK_EN
  logic [HC_DATA_W-1:0] r_byte;
  logic                 r_enc_err;

  // Recompute the codeword for the byte in flight; the result is still queued
  always_ff @(posedge clk) begin
    if (rst) begin
      r_enc_err <= 1'b0;
    end else begin
      if (w_fire) r_byte <= w_enc_data;
      if (r_inflight && (enc_hc != hc_encode(r_byte))) r_enc_err <= 1'b1;
    end
  end

  assign enc_err = r_enc_err;
`else
  assign enc_err = 1'b0;
`endif

endmodule

// File: tb/tb_hamming_tx_sched.sv
// Directed bench for hamming_tx_sched with a behavioural single-cycle encoder.
module tb_hamming_tx_sched;

  localparam int NUM_REQ    = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int SRC_W      = 1;

`ifdef HAMMING_TX_SCHED_CHK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic                 clk;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 enc_wren;
  logic [7:0]           enc_data;
  logic [11:0]          enc_hc;
  logic                 cw_valid;
  logic [11:0]          cw_data;
  logic [SRC_W-1:0]     cw_src;
  logic                 cw_ready;
  logic                 busy;
  logic                 enc_err;

  logic [11:0] flip;
  int          n_pass;
  int          n_chk;
  int          accepts;
  logic [12:0] exp_q[$];
  logic [12:0] exp_item;
  logic [1:0]  exp_rdy;
  logic [7:0]  b;

  hamming_tx_sched #(
    .NUM_REQ    (NUM_REQ),
    .FIFO_DEPTH (FIFO_DEPTH),
    .SRC_W      (SRC_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .enc_wren  (enc_wren),
    .enc_data  (enc_data),
    .enc_hc    (enc_hc),
    .cw_valid  (cw_valid),
    .cw_data   (cw_data),
    .cw_src    (cw_src),
    .cw_ready  (cw_ready),
    .busy      (busy),
    .enc_err   (enc_err)
  );

  // ---------------- clock / reset / encoder ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] ref_hc(input logic [7:0] d);
    logic p0, p1, p2, p3;
    p0 = d[6] ^ d[4] ^ d[3] ^ d[1] ^ d[0];
    p1 = d[6] ^ d[5] ^ d[3] ^ d[2] ^ d[0];
    p2 = d[7] ^ d[3] ^ d[2] ^ d[1];
    p3 = d[7] ^ d[6] ^ d[5] ^ d[4];
    return {d[7], d[6], d[5], d[4], p3, d[3], d[2], d[1], p2, d[0], p1, p0};
  endfunction

  always @(posedge clk) enc_hc <= enc_wren ? (ref_hc(enc_data) ^ flip) : 12'h000;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    flip      = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    n_pass    = 0;
    n_chk     = 0;
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    cw_ready  = 1'b0;
    flip      = '0;

    // Reset state
    do_reset();
    check_eq("rst_cw_valid", 32'(cw_valid), 32'd0);
    check_eq("rst_busy",     32'(busy),     32'd0);
    check_eq("rst_req_ready",32'(req_ready),32'd0);
    check_eq("rst_enc_wren", 32'(enc_wren), 32'd0);
    check_eq("rst_enc_err",  32'(enc_err),  32'd0);

    // Single byte 0xA5 from req0
    cw_ready  = 1'b1;
    req_valid = 2'b01;
    req_data  = 16'h00A5;
    #1;
    check_eq("t1_ready",    32'(req_ready), 32'h1);
    check_eq("t1_wren",     32'(enc_wren),  32'h1);
    check_eq("t1_enc_data", 32'(enc_data),  32'hA5);
    tick();
    req_valid = '0;
    #1;
    check_eq("t1_lat1_valid", 32'(cw_valid), 32'd0);
    check_eq("t1_lat1_busy",  32'(busy),     32'd1);
    check_eq("t1_idle_wren",  32'(enc_wren), 32'd0);
    check_eq("t1_idle_data",  32'(enc_data), 32'd0);
    tick();
    check_eq("t1_valid", 32'(cw_valid), 32'd1);
    check_eq("t1_data",  32'(cw_data),  32'hA27);
    check_eq("t1_src",   32'(cw_src),   32'd0);
    tick();
    check_eq("t1_empty", 32'(cw_valid), 32'd0);
    check_eq("t1_idle",  32'(busy),     32'd0);

    // Two requesters, alternating grants at full rate
    do_reset();
    cw_ready  = 1'b1;
    req_valid = 2'b11;
    req_data  = 16'h00FF;
    for (int k = 0; k < 8; k++) begin
      #1;
      exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
      check_eq("t2_grant", 32'(req_ready), 32'(exp_rdy));
      if (k >= 2) begin
        check_eq("t2_valid", 32'(cw_valid), 32'd1);
        check_eq("t2_data",  32'(cw_data),  (k % 2 == 0) ? 32'hF77 : 32'h000);
        check_eq("t2_src",   32'(cw_src),   32'(k % 2));
      end
      tick();
    end
    req_valid = '0;
    for (int k = 0; k < 10 && busy; k++) tick();
    check_eq("t2_drain", 32'(busy), 32'd0);

    // Back-pressure: exactly FIFO_DEPTH accepts, then ordered drain
    do_reset();
    cw_ready  = 1'b0;
    req_valid = 2'b01;
    accepts   = 0;
    for (int k = 0; k < 8; k++) begin
      b        = 8'(8'h10 + accepts);
      req_data = {8'h00, b};
      #1;
      if (req_ready[0]) begin
        exp_q.push_back({1'b0, ref_hc(b)});
        accepts++;
      end
      tick();
    end
    check_eq("t3_accepts", 32'(accepts), 32'd4);
    check_eq("t3_full_ready", 32'(req_ready), 32'd0);
    cw_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      req_valid = (k < 6) ? 2'b01 : 2'b00;
      b         = 8'(8'h10 + accepts);
      req_data  = {8'h00, b};
      #1;
      if (k == 0) check_eq("t3_no_credit_on_pop", 32'(req_ready), 32'd0);
      if (k == 1) check_eq("t3_credit_after_pop", 32'(req_ready), 32'h1);
      if (cw_valid) begin
        if (exp_q.size() > 0) begin
          exp_item = exp_q.pop_front();
          check_eq("t3_order", 32'({cw_src, cw_data}), 32'(exp_item));
        end else begin
          check_eq("t3_unexpected", 32'({cw_src, cw_data}), 32'h1FFFF);
        end
      end
      if (req_ready[0]) begin
        exp_q.push_back({1'b0, ref_hc(b)});
        accepts++;
      end
      tick();
    end
    check_eq("t3_total",    32'(accepts),      32'd9);
    check_eq("t3_q_empty",  32'(exp_q.size()), 32'd0);
    check_eq("t3_drained",  32'(cw_valid),     32'd0);

    // Reset with an encode in flight
    do_reset();
    cw_ready  = 1'b1;
    req_valid = 2'b01;
    req_data  = 16'h00A5;
    #1;
    check_eq("t4_grant", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    rst       = 1'b1;
    #1;
    check_eq("t4_in_rst_valid", 32'(cw_valid), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check_eq("t4_valid", 32'(cw_valid), 32'd0);
    check_eq("t4_busy",  32'(busy),     32'd0);
    tick();
    check_eq("t4_no_ghost", 32'(cw_valid), 32'd0);
    req_valid = 2'b11;
    req_data  = 16'h0000;
    #1;
    check_eq("t4_rr_ptr0", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    tick();
    tick();
    tick();

    // Simultaneous push and pop with two entries queued
    do_reset();
    cw_ready  = 1'b0;
    req_valid = 2'b01;
    req_data  = 16'h003C;
    #1;
    check_eq("t5_acc0", 32'(req_ready), 32'h1);
    tick();
    req_data = 16'h005A;
    #1;
    check_eq("t5_acc1", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    tick();
    req_valid = 2'b01;
    req_data  = 16'h00C3;
    #1;
    check_eq("t5_acc2", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    cw_ready  = 1'b1;
    #1;
    check_eq("t5_head0", 32'({cw_src, cw_data}), 32'({1'b0, ref_hc(8'h3C)}));
    tick();
    check_eq("t5_head1", 32'({cw_src, cw_data}), 32'({1'b0, ref_hc(8'h5A)}));
    tick();
    check_eq("t5_head2", 32'({cw_src, cw_data}), 32'({1'b0, ref_hc(8'hC3)}));
    tick();
    check_eq("t5_count2", 32'(cw_valid), 32'd0);

    // Encoder fault: bit 0 flipped for 0xA5
    do_reset();
    cw_ready  = 1'b1;
    flip      = 12'h001;
    req_valid = 2'b01;
    req_data  = 16'h00A5;
    tick();
    flip      = '0;
    req_valid = '0;
    #1;
    check_eq("t6_err_not_yet", 32'(enc_err), 32'd0);
    tick();
    check_eq("t6_pushed", 32'(cw_data), 32'hA26);
    check_eq("t6_err",    32'(enc_err), 32'(EXP_ERR));
    req_valid = 2'b01;
    req_data  = 16'h00FF;
    tick();
    req_valid = '0;
    tick();
    tick();
    check_eq("t6_sticky", 32'(enc_err), 32'(EXP_ERR));
    do_reset();
    check_eq("t6_rst_clear", 32'(enc_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hamming_tx_sched.md
Name: hamming_tx_sched

Overview:
Round-robin scheduler that shares one external single-cycle Hamming(12,8) encoder between NUM_REQ byte requesters in the transceiver TX path.
Accepts bytes over per-requester valid/ready and drives the encoder's write-enable and data.
Captures the returned 12-bit codeword, tags it with the source index, and buffers it in an output FIFO.
Presents codewords downstream over valid/ready toward the serializer.

Parameters:
NUM_REQ, 2, number of byte requesters (2..8)
FIFO_DEPTH, 4, output codeword FIFO entries (power of 2, >=2)
SRC_W, $clog2(NUM_REQ) (min 1), width of source tag

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  byte valid per requester
req_data  in  NUM_REQ*8  byte per requester; requester i at bits [8i+7:8i]
req_ready  out  NUM_REQ  grant/accept per requester (one-hot or zero)
enc_wren  out  1  encoder write enable
enc_data  out  8  byte to encoder
enc_hc  in  12  encoder codeword, valid the cycle after enc_wren (encoder outputs 0 otherwise)
cw_valid  out  1  output FIFO non-empty
cw_data  out  12  head codeword
cw_src  out  SRC_W  requester index of head codeword
cw_ready  in  1  downstream accept
busy  out  1  in-flight encode or FIFO non-empty
enc_err  out  1  sticky encoder-check error (feature-dependent)

Behaviour:
- Reset (synchronous, rst=1 at clock edge):
  - FIFO flushed, in-flight flag cleared, rr pointer = 0, enc_err = 0.
  - Outputs while/after reset: cw_valid=0, busy=0, req_ready=0, enc_wren=0.
  - An encode in flight at reset is discarded.
- Credit: issue allowed iff (fifo_count + inflight) < FIFO_DEPTH. A pop in the same cycle does NOT add credit (registered count only).
- Arbitration (combinational):
  - If credit, grant the first requester with req_valid, searching from rr pointer upward with wrap.
  - req_ready[g] = 1 for the granted requester only; never asserted without credit.
  - req_ready is independent of req_valid for non-granted lines (they see 0).
- Handshake cycle t (req_valid[g] & req_ready[g]):
  - enc_wren = 1 and enc_data = req_data[g] in the same cycle (combinational).
  - Registered: inflight = 1, tag = g; rr pointer = (g+1) mod NUM_REQ.
  - No grant: enc_wren = 0, enc_data = 0, rr pointer unchanged.
- Cycle t+1: enc_hc is pushed into the FIFO with its tag at the end of the cycle; inflight cleared unless a new grant occurs in t+1.
- Throughput and latency:
  - One byte per cycle sustained when cw_ready = 1.
  - Accept-to-cw_valid latency is 2 cycles when the FIFO is empty.
- FIFO:
  - Pop on cw_valid & cw_ready; push and pop in the same cycle are allowed (count unchanged).
  - Pointers wrap mod FIFO_DEPTH.
  - cw_data/cw_src held stable while cw_valid & !cw_ready.
  - Overflow cannot occur given the credit rule; underflow is prevented because pops are gated by cw_valid.
- Codeword layout (bit 11..0): d7 d6 d5 d4 p3 d3 d2 d1 p2 d0 p1 p0; the block passes enc_hc through unchanged.
- busy = inflight | (fifo_count != 0).

Optional Feature:
Macro HAMMING_TX_SCHED_CHK_EN.
- Defined:
  - The block keeps a copy of the in-flight byte.
  - At t+1 it recomputes p0=d6^d4^d3^d1^d0, p1=d6^d5^d3^d2^d0, p2=d7^d3^d2^d1, p3=d7^d6^d5^d4.
  - Any mismatch against enc_hc (data or parity bit) sets enc_err, which stays set until rst.
  - The codeword is still pushed.
- Undefined: enc_err tied 0; no byte copy or checker logic.

Decomposition:
- Shared package hamming_pkg:
  - Constants HC_DATA_W=8 and HC_CW_W=12.
  - Bit-position constants for p0..p3 and d0..d7 in the codeword.
  - A parity function used by the checker.
- Natural sub-module rr_arbiter: NUM_REQ request vector plus pointer in, one-hot grant out.
- FIFO stays inline.

Test Plan:
- Single req0 byte 0xA5, cw_ready=1 -> enc_wren pulse with enc_data=0xA5; two cycles later cw_valid=1, cw_data=0xA27, cw_src=0.
- req0 and req1 both valid continuously (0xFF / 0x00) -> grants alternate 0,1,0,1; output sequence 0xF77/src0, 0x000/src1, repeated at 1 per cycle.
- cw_ready=0 with req0 always valid -> exactly FIFO_DEPTH accepts, then req_ready=0. Raise cw_ready -> FIFO drains in order, one new accept per pop cycle after the count drops.
- Raise rst in the cycle after a grant (encode in flight) -> next cycle cw_valid=0 and busy=0, rr pointer=0; the in-flight codeword never appears.
- Simultaneous push and pop with fifo_count=2 -> count stays 2 and order is preserved.
- With HAMMING_TX_SCHED_CHK_EN: force enc_hc bit 0 flipped for byte 0xA5 -> enc_err=1 and sticky until rst. Without the macro: enc_err stays 0.
